// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit DATA_PATH: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath enable and select.
module multicycle_controller #(
  parameter int unsigned WATCHDOG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_go,
  input  logic [15:0] i_inst,
  input  logic        i_zero,
  output logic        o_pc_clear,
  output logic        o_pc_write,
  output logic [1:0]  o_pc_src,
  output logic        o_ir_write,
  output logic        o_reg_write,
  output logic        o_reg_dst,
  output logic        o_alu_src,
  output logic [2:0]  o_alu_ctrl,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_mem_to_reg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_illegal,
  output logic [15:0] o_instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_HALTED = 3'd7;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQZ = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_instr_count;
  logic        r_illegal;
  logic [3:0]  w_op;
  logic        w_legal;
  logic        w_wd_hit;
  logic [2:0]  w_after;
  logic        w_unused_inst;

  assign w_op          = i_inst[15:12];
  assign w_legal       = (w_op <= OP_JMP);
  assign w_unused_inst = ^i_inst[11:3];

  // Every instruction's final state exits through w_after, so the watchdog
  // only has to be applied in one place.
  assign w_wd_hit = (WATCHDOG != 0) && (r_instr_count == 16'(WATCHDOG));
  assign w_after  = w_wd_hit ? S_HALTED : S_FETCH;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (i_go) w_next = S_INIT;
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_HALT)  w_next = S_HALTED;
        else if (!w_legal)    w_next = w_after;
        else                  w_next = S_EXEC;
      end
      S_EXEC: begin
        case (w_op)
          OP_R, OP_ADDI: w_next = S_WB;
          OP_LW, OP_SW:  w_next = S_MEM;
          default:       w_next = w_after;
        endcase
      end
      S_MEM:    w_next = (w_op == OP_LW) ? S_WB : w_after;
      S_WB:     w_next = w_after;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_instr_count <= '0;
      r_illegal     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_INIT) begin
        r_instr_count <= '0;
        r_illegal     <= 1'b0;
      end else if (r_state == S_FETCH) begin
        r_instr_count <= r_instr_count + 16'd1;
      end else if (r_state == S_DECODE && !w_legal && w_op != OP_HALT) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    o_pc_clear   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'b00;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_alu_src    = 1'b0;
    o_alu_ctrl   = 3'b000;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    case (r_state)
      S_INIT:  o_pc_clear = 1'b1;
      S_FETCH: begin
        o_ir_write = 1'b1;
        o_pc_write = 1'b1;
      end
      S_EXEC: begin
        case (w_op)
          OP_R:                  o_alu_ctrl = i_inst[2:0];
          OP_ADDI, OP_LW, OP_SW: o_alu_src  = 1'b1;
          OP_BEQZ: begin
            o_alu_ctrl = 3'b111;
            o_pc_write = i_zero;
            o_pc_src   = 2'b01;
          end
          OP_JMP: begin
            o_pc_write = 1'b1;
            o_pc_src   = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        o_mem_read  = (w_op == OP_LW);
        o_mem_write = (w_op == OP_SW);
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = (w_op == OP_R);
        o_mem_to_reg = (w_op == OP_LW);
      end
      default: ;
    endcase
  end

  assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign o_done        = (r_state == S_HALTED);
  assign o_illegal     = r_illegal;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (watchdog off / 3),
// stimulus queues per-cycle expected outputs, a negedge monitor compares.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go, go1, zero;
  logic [15:0] inst;

  logic        pcc0, pcw0, irw0, rw0, rdst0, asrc0, mr0, mw0, m2r0, busy0, done0, ill0;
  logic [1:0]  src0;
  logic [2:0]  actl0;
  logic [15:0] cnt0;
  logic        pcc1, pcw1, irw1, rw1, rdst1, asrc1, mr1, mw1, m2r1, busy1, done1, ill1;
  logic [1:0]  src1;
  logic [2:0]  actl1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  multicycle_controller #(.WATCHDOG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_inst(inst), .i_zero(zero),
    .o_pc_clear(pcc0), .o_pc_write(pcw0), .o_pc_src(src0), .o_ir_write(irw0),
    .o_reg_write(rw0), .o_reg_dst(rdst0), .o_alu_src(asrc0), .o_alu_ctrl(actl0),
    .o_mem_read(mr0), .o_mem_write(mw0), .o_mem_to_reg(m2r0), .o_busy(busy0),
    .o_done(done0), .o_illegal(ill0), .o_instr_count(cnt0));

  multicycle_controller #(.WATCHDOG(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_go(go1), .i_inst(inst), .i_zero(zero),
    .o_pc_clear(pcc1), .o_pc_write(pcw1), .o_pc_src(src1), .o_ir_write(irw1),
    .o_reg_write(rw1), .o_reg_dst(rdst1), .o_alu_src(asrc1), .o_alu_ctrl(actl1),
    .o_mem_read(mr1), .o_mem_write(mw1), .o_mem_to_reg(m2r1), .o_busy(busy1),
    .o_done(done1), .o_illegal(ill1), .o_instr_count(cnt1));

  // Packed control word: {pc_clear, pc_write, pc_src, ir_write, reg_write, reg_dst,
  // alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg, busy, done, illegal}
  localparam logic [16:0] V0   = 17'h00000;
  localparam logic [16:0] PCC  = 17'h10000;
  localparam logic [16:0] PCW  = 17'h08000;
  localparam logic [16:0] SRC2 = 17'h04000;
  localparam logic [16:0] SRC1 = 17'h02000;
  localparam logic [16:0] IRW  = 17'h01000;
  localparam logic [16:0] RW   = 17'h00800;
  localparam logic [16:0] RDST = 17'h00400;
  localparam logic [16:0] ASRC = 17'h00200;
  localparam logic [16:0] ACT7 = 17'h001C0;
  localparam logic [16:0] ACT1 = 17'h00040;
  localparam logic [16:0] MR   = 17'h00020;
  localparam logic [16:0] MW   = 17'h00010;
  localparam logic [16:0] M2R  = 17'h00008;
  localparam logic [16:0] BUSY = 17'h00004;
  localparam logic [16:0] DONE = 17'h00002;
  localparam logic [16:0] ILL  = 17'h00001;
  localparam logic [16:0] INIT  = PCC | BUSY;
  localparam logic [16:0] FETCH = PCW | IRW | BUSY;
  localparam logic [16:0] DEC   = BUSY;

  typedef struct {
    string       nm;
    bit          sel;
    logic [16:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [16:0] act0, act1;
  assign act0 = {pcc0, pcw0, src0, irw0, rw0, rdst0, asrc0, actl0, mr0, mw0, m2r0, busy0, done0, ill0};
  assign act1 = {pcc1, pcw1, src1, irw1, rw1, rdst1, asrc1, actl1, mr1, mw1, m2r1, busy1, done1, ill1};

  exp_t        e;
  logic [16:0] a_ctl;
  logic [15:0] a_cnt;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e     = q.pop_front();
      a_ctl = e.sel ? act1 : act0;
      a_cnt = e.sel ? cnt1 : cnt0;
      n_checks++;
      if (a_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %05h expected %05h", e.nm, a_ctl, e.ctl);
      end
      n_checks++;
      if (a_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL %s instr_count: got %04h expected %04h", e.nm, a_cnt, e.cnt);
      end
    end
  end

  task automatic cyc(input string nm, input logic [16:0] v, input logic [15:0] c,
                     input bit sel = 1'b0);
    q.push_back('{nm, sel, v, c});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; go1 = 1'b0; zero = 1'b0; inst = 16'hF000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("reset", V0, 16'd0);

    // HALT-only program
    go = 1'b1; cyc("t1_go", V0, 16'd0); go = 1'b0;
    cyc("t1_init", INIT, 16'd0);
    cyc("t1_fetch", FETCH, 16'd0);
    cyc("t1_decode", DEC, 16'd1);
    cyc("t1_halted", DONE, 16'd1);
    cyc("t1_halted_hold", DONE, 16'd1);

    // ADD, LW, SW, HALT
    go = 1'b1; cyc("t2_go", DONE, 16'd1); go = 1'b0;
    cyc("t2_init", INIT, 16'd1);
    inst = 16'h0001;
    cyc("t2_add_fetch", FETCH, 16'd0);
    cyc("t2_add_dec", DEC, 16'd1);
    cyc("t2_add_exec", BUSY | ACT1, 16'd1);
    cyc("t2_add_wb", RW | RDST | BUSY, 16'd1);
    inst = 16'h2123;
    cyc("t2_lw_fetch", FETCH, 16'd1);
    cyc("t2_lw_dec", DEC, 16'd2);
    cyc("t2_lw_exec", BUSY | ASRC, 16'd2);
    cyc("t2_lw_mem", MR | BUSY, 16'd2);
    cyc("t2_lw_wb", RW | M2R | BUSY, 16'd2);
    inst = 16'h3456;
    cyc("t2_sw_fetch", FETCH, 16'd2);
    cyc("t2_sw_dec", DEC, 16'd3);
    cyc("t2_sw_exec", BUSY | ASRC, 16'd3);
    cyc("t2_sw_mem", MW | BUSY, 16'd3);
    inst = 16'hF000;
    cyc("t2_halt_fetch", FETCH, 16'd3);
    cyc("t2_halt_dec", DEC, 16'd4);
    cyc("t2_halted", DONE, 16'd4);

    // BEQZ taken, BEQZ not taken, HALT
    go = 1'b1; cyc("t3_go", DONE, 16'd4); go = 1'b0;
    cyc("t3_init", INIT, 16'd4);
    inst = 16'h4005; zero = 1'b1;
    cyc("t3_beq1_fetch", FETCH, 16'd0);
    cyc("t3_beq1_dec", DEC, 16'd1);
    cyc("t3_beq1_exec_taken", BUSY | PCW | SRC1 | ACT7, 16'd1);
    cyc("t3_beq2_fetch", FETCH, 16'd1);
    cyc("t3_beq2_dec", DEC, 16'd2);
    zero = 1'b0;
    cyc("t3_beq2_exec_not_taken", BUSY | SRC1 | ACT7, 16'd2);
    inst = 16'hF000; zero = 1'b1;
    cyc("t3_halt_fetch", FETCH, 16'd2);
    cyc("t3_halt_dec", DEC, 16'd3);
    cyc("t3_halted", DONE, 16'd3);

    // Illegal opcode, sticky flag, clear on go, then reset during SW MEM
    go = 1'b1; cyc("t4_go", DONE, 16'd3); go = 1'b0;
    cyc("t4_init", INIT, 16'd3);
    inst = 16'h7000;
    cyc("t4_ill_fetch", FETCH, 16'd0);
    cyc("t4_ill_dec", DEC, 16'd1);
    inst = 16'hF000;
    cyc("t4_halt_fetch", FETCH | ILL, 16'd1);
    cyc("t4_halt_dec", DEC | ILL, 16'd2);
    cyc("t4_halted_ill", DONE | ILL, 16'd2);
    go = 1'b1; cyc("t4_go2", DONE | ILL, 16'd2); go = 1'b0;
    cyc("t4_init2", INIT | ILL, 16'd2);
    inst = 16'h3000;
    cyc("t4_sw_fetch", FETCH, 16'd0);
    cyc("t4_sw_dec", DEC, 16'd1);
    cyc("t4_sw_exec", BUSY | ASRC, 16'd1);
    q.push_back('{"t4_rst_async_in_mem", 1'b0, V0, 16'd0});
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    cyc("t4_rst_hold", V0, 16'd0);
    rst_n = 1'b1;
    cyc("t4_post_rst1", V0, 16'd0);
    cyc("t4_post_rst2", V0, 16'd0);
    go = 1'b1; cyc("t4_go3", V0, 16'd0); go = 1'b0;
    cyc("t4_init3", INIT, 16'd0);
    inst = 16'hF000;
    cyc("t4_halt_fetch3", FETCH, 16'd0);
    cyc("t4_halt_dec3", DEC, 16'd1);
    cyc("t4_halted3", DONE, 16'd1);

    // Watchdog instance: JMP-to-self loop halts after 3 instructions
    inst = 16'h5000;
    go1 = 1'b1; cyc("t5_go", V0, 16'd0, 1'b1); go1 = 1'b0;
    cyc("t5_init", INIT, 16'd0, 1'b1);
    cyc("t5_j1_fetch", FETCH, 16'd0, 1'b1);
    cyc("t5_j1_dec", DEC, 16'd1, 1'b1);
    cyc("t5_j1_exec", PCW | SRC2 | BUSY, 16'd1, 1'b1);
    go1 = 1'b1;
    cyc("t5_j2_fetch_go_ignored", FETCH, 16'd1, 1'b1);
    go1 = 1'b0;
    cyc("t5_j2_dec", DEC, 16'd2, 1'b1);
    cyc("t5_j2_exec", PCW | SRC2 | BUSY, 16'd2, 1'b1);
    cyc("t5_j3_fetch", FETCH, 16'd2, 1'b1);
    cyc("t5_j3_dec", DEC, 16'd3, 1'b1);
    cyc("t5_j3_exec", PCW | SRC2 | BUSY, 16'd3, 1'b1);
    cyc("t5_wd_halted", DONE, 16'd3, 1'b1);
    cyc("t5_wd_halted_hold", DONE, 16'd3, 1'b1);

    repeat (2) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM that sequences the 16-bit/12-bit-PC `DATA_PATH` through fetch, decode, execute, memory and write-back for one instruction at a time. It sits beside the datapath and drives every datapath write-enable and mux select. It consumes the datapath's instruction register and ALU `ZERO` flag. A one-cycle `go` pulse starts a program run from PC 0. The run ends on a HALT opcode, after which the block waits for the next `go`.

## Interface
- `WATCHDOG`, default 0: maximum instructions per run before a forced halt; 0 disables the limit.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `go`  in  1: start request; sampled only in IDLE and HALTED.
- `inst`  in  16: instruction register contents; opcode = `inst[15:12]`, function = `inst[2:0]`.
- `zero`  in  1: ALU zero flag from the datapath.
- `pc_clear`  out  1: clear PC to 0.
- `pc_write`  out  1: PC load enable.
- `pc_src`  out  2: PC source; 00 = PC+1, 01 = branch target, 10 = jump target.
- `ir_write`  out  1: instruction register load.
- `reg_write`  out  1: register-file write.
- `reg_dst`  out  1: destination select; 1 = rd for R-type, 0 = rt.
- `alu_src`  out  1: ALU B operand; 1 = sign-extended immediate, 0 = register.
- `alu_ctrl`  out  3: ALU operation.
- `mem_read`  out  1: data-memory read strobe.
- `mem_write`  out  1: data-memory write strobe.
- `mem_to_reg`  out  1: write-back data source; 1 = memory, 0 = ALU.
- `busy`  out  1: high in every state except IDLE and HALTED.
- `done`  out  1: high in HALTED.
- `illegal`  out  1: sticky flag, set on an undefined opcode.
- `instr_count`  out  16: number of instructions fetched in the current run.

## Operation
- States: IDLE, INIT, FETCH, DECODE, EXEC, MEM, WB, HALTED. All outputs are Moore outputs decoded from the registered state plus the stable `inst`, except the branch `pc_write`, which also uses `zero`.
- Opcodes:
  - 0 R-type: `alu_ctrl` = `inst[2:0]`.
  - 1 ADDI.
  - 2 LW.
  - 3 SW.
  - 4 BEQZ.
  - 5 JMP.
  - F HALT.
  - All other opcodes are illegal.
- IDLE/HALTED: when `go`=1, go to INIT. Otherwise stay.
- INIT: assert `pc_clear`. Clear `instr_count` and `illegal`. Then go to FETCH.
- FETCH: assert `ir_write`, `pc_write`, `pc_src`=00, and increment `instr_count` (wraps FFFF -> 0000). Then go to DECODE.
- DECODE: assert no control outputs.
  - HALT -> HALTED.
  - Illegal opcode -> set `illegal`, go to FETCH (executed as a NOP).
  - All other opcodes -> EXEC.
- EXEC:
  - R-type, ADDI, LW, SW: `alu_ctrl` as decoded. ADDI, LW and SW use `alu_ctrl`=000 (ADD) with `alu_src`=1.
  - BEQZ: `alu_ctrl`=111 (pass A). `pc_write` = `zero`, `pc_src`=01.
  - JMP: `pc_write`=1, `pc_src`=10.
  - Next state: R-type/ADDI -> WB; LW/SW -> MEM; BEQZ/JMP -> FETCH.
- MEM:
  - LW: `mem_read`=1, then WB.
  - SW: `mem_write`=1, then FETCH.
- WB: `reg_write`=1. `reg_dst`=1 only for R-type. `mem_to_reg`=1 only for LW. Then go to FETCH.
- Watchdog: if `WATCHDOG`≠0 and `instr_count` = `WATCHDOG` at the end of any instruction's last state, go to HALTED instead of FETCH.
- `go` while `busy`=1 is ignored.

## Timing
- Reset value of every output is 0, with state IDLE. `instr_count` = 0 and `illegal` = 0.
- `rst_n` asserted mid-instruction returns the block to IDLE immediately, with all strobes low in the same cycle; no partial write is issued afterward.
- Latency from `go` sampled high: `pc_clear` is high on the next cycle, and the first FETCH follows one cycle after that.
- Cycles per instruction:
  - R-type and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQZ and JMP: 3.
  - Illegal opcode: 2.
  - HALT: 2 cycles, then HALTED.
- `done` rises in the cycle after the HALT instruction's DECODE and holds until `go` or reset.
- `zero` is sampled only during EXEC of a BEQZ. The datapath must present a settled flag within that cycle.
- At most one of `mem_read`, `mem_write`, `reg_write`, `ir_write` is high in any cycle.

## Test plan
- Reset then `go` pulse with `inst`=F000 → INIT, FETCH, DECODE, then HALTED. `done`=1 and `instr_count`=1 from cycle 4.
- Program ADD (0x0001), LW (0x2xxx), SW (0x3xxx), HALT → cycle counts 4/5/4/2 are met. `reg_dst`/`mem_to_reg`/`mem_read`/`mem_write` pulse in the specified states. `instr_count`=4.
- BEQZ with `zero`=1 → a single `pc_write` with `pc_src`=01 in EXEC. With `zero`=0 → no `pc_write` in EXEC.
- Opcode 0x7 → `illegal`=1 and 2-cycle NOP. The flag stays set through HALT and clears on the next `go`.
- `rst_n` low during MEM of SW → all outputs go to 0 asynchronously and `mem_write` never reasserts. `go` after release restarts from INIT.
- `WATCHDOG`=3 with a JMP-to-self loop → HALTED after the 3rd instruction, with `done`=1 and `instr_count`=3. `go` asserted mid-run is ignored.
